// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 20-bit pipelined core.
// Owns the PC and the single memory address port, fills the IF/ID register,
// yields the port to the MEM stage on request, and parks in HALT once the
// last code address has been fetched.
module fetch_stage #(
    parameter logic [4:0]  RESET_PC = 5'd0,
    parameter logic [4:0]  LAST_PC  = 5'd28,
    parameter logic [19:0] NOP_WORD = 20'h00000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [4:0]  redirect_pc,
    input  logic        dmem_req,
    input  logic [4:0]  dmem_addr,
    output logic [4:0]  mem_addr,
    input  logic [19:0] mem_q,
    output logic [19:0] ifid_instr,
    output logic [4:0]  ifid_pc,
    output logic        ifid_valid,
    output logic [4:0]  pc,
    output logic        halted
);

    // YIELD only records that the previous cycle went to the MEM stage;
    // it behaves exactly like RUN.
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_YIELD = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_pc,    w_pc_nxt;
    logic [19:0] r_instr, w_instr_nxt;
    logic [4:0]  r_ipc,   w_ipc_nxt;
    logic        r_valid, w_valid_nxt;

    // Port arbitration: the MEM stage wins whenever it asks, in every state.
    always_comb begin
        mem_addr = dmem_req ? dmem_addr : r_pc;
    end

    // Next-state and IF/ID update: redirect > stall > dmem_req > fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_ipc_nxt   = r_ipc;
        w_valid_nxt = r_valid;
        if (redirect_en) begin
            // Flush and restart; an out-of-code target halts on its first fetch.
            w_pc_nxt    = redirect_pc;
            w_instr_nxt = NOP_WORD;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_RUN;
        end else if (stall) begin
            // Hold everything; the port grant above is unaffected.
            w_state_nxt = r_state;
        end else if (dmem_req) begin
            w_instr_nxt = NOP_WORD;
            w_valid_nxt = 1'b0;
            w_state_nxt = (r_state == S_HALT) ? S_HALT : S_YIELD;
        end else if (r_state == S_HALT) begin
            w_instr_nxt = NOP_WORD;
            w_valid_nxt = 1'b0;
        end else if (r_pc <= LAST_PC) begin
            w_instr_nxt = mem_q;
            w_ipc_nxt   = r_pc;
            w_valid_nxt = 1'b1;
            if (r_pc == LAST_PC) begin
                w_state_nxt = S_HALT;
            end else begin
                w_pc_nxt    = r_pc + 5'd1;
                w_state_nxt = S_RUN;
            end
        end else begin
            // PC beyond the code region: bubble and stop.
            w_instr_nxt = NOP_WORD;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_HALT;
        end
    end

    // State and IF/ID registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= S_RUN;
            r_pc    <= RESET_PC;
            r_instr <= NOP_WORD;
            r_ipc   <= 5'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_ipc   <= w_ipc_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign pc         = r_pc;
    assign ifid_instr = r_instr;
    assign ifid_pc    = r_ipc;
    assign ifid_valid = r_valid;
    assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run, all checked
// against a behavioural model of the fetch rules kept in this file.
module tb_fetch_stage;

    logic        Clock = 1'b0;
    logic        Resetn, stall, redirect_en, dmem_req;
    logic [4:0]  redirect_pc, dmem_addr, mem_addr, ifid_pc, pc;
    logic [19:0] mem_q, ifid_instr;
    logic        ifid_valid, halted;

    logic [19:0] mem [32];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [4:0]  m_pc, m_ipc;
    logic [19:0] m_instr;
    logic        m_valid, m_halt;
    logic [4:0]  seen_maddr;

    fetch_stage dut (
        .Clock(Clock), .Resetn(Resetn), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .mem_addr(mem_addr), .mem_q(mem_q), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_valid(ifid_valid), .pc(pc), .halted(halted)
    );

    always #5 Clock = ~Clock;
    assign mem_q = mem[mem_addr];

    task automatic load_mem();
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a;
            a = 5'(i);
            mem[i] = (i <= 28) ? {4'hF, a[3:0], 12'h0} : 20'($urandom);
        end
    endtask

    // Drive one cycle: apply inputs, sample mem_addr, step the model at the edge.
    task automatic cyc(input logic rn, input logic st, input logic re,
                       input logic [4:0] rp, input logic dr, input logic [4:0] da);
        logic [4:0]  n_pc, n_ipc;
        logic [19:0] n_instr;
        logic        n_valid, n_halt;
        Resetn = rn; stall = st; redirect_en = re; redirect_pc = rp;
        dmem_req = dr; dmem_addr = da;
        #1;
        seen_maddr = mem_addr;
        n_pc = m_pc; n_ipc = m_ipc; n_instr = m_instr; n_valid = m_valid; n_halt = m_halt;
        if (!rn) begin
            n_pc = 5'd0; n_ipc = 5'd0; n_instr = 20'h0; n_valid = 1'b0; n_halt = 1'b0;
        end else if (re) begin
            n_pc = rp; n_instr = 20'h0; n_valid = 1'b0; n_halt = 1'b0;
        end else if (st) begin
            n_pc = m_pc;
        end else if (dr) begin
            n_instr = 20'h0; n_valid = 1'b0;
        end else if (m_halt || m_pc > 5'd28) begin
            n_instr = 20'h0; n_valid = 1'b0; n_halt = 1'b1;
        end else begin
            n_instr = mem[m_pc]; n_ipc = m_pc; n_valid = 1'b1;
            if (m_pc == 5'd28) n_halt = 1'b1;
            else n_pc = m_pc + 5'd1;
        end
        @(posedge Clock);
        #1;
        m_pc = n_pc; m_ipc = n_ipc; m_instr = n_instr; m_valid = n_valid; m_halt = n_halt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 5'd0, 0, 5'd0);
    endtask

    task automatic test_reset();
        load_mem();
        cyc(0, 0, 0, 5'd0, 0, 5'd0);
        checks++;
        if ({pc, ifid_instr, ifid_pc, ifid_valid, halted} !== {5'd0, 20'h0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: pc=%0d instr=%h ipc=%0d v=%b h=%b expected all zero",
                     pc, ifid_instr, ifid_pc, ifid_valid, halted);
        end
    endtask

    task automatic test_free_run();
        cyc(0, 0, 0, 5'd0, 0, 5'd0);
        for (int k = 1; k <= 32; k++) begin
            logic [4:0] e_ipc, e_pc;
            logic       e_v, e_h;
            logic [19:0] e_ins;
            idle(1);
            e_v   = (k <= 29);
            e_h   = (k >= 29);
            e_ipc = (k <= 29) ? 5'(k - 1) : 5'd28;
            e_pc  = (k <= 28) ? 5'(k) : 5'd28;
            e_ins = e_v ? {4'hF, e_ipc[3:0], 12'h0} : 20'h0;
            checks++;
            if ({ifid_valid, halted, ifid_pc, pc, ifid_instr} !== {e_v, e_h, e_ipc, e_pc, e_ins}) begin
                errors++;
                $display("FAIL free_run edge %0d: v=%b h=%b ipc=%0d pc=%0d instr=%h expected v=%b h=%b ipc=%0d pc=%0d instr=%h",
                         k, ifid_valid, halted, ifid_pc, pc, ifid_instr, e_v, e_h, e_ipc, e_pc, e_ins);
            end
        end
    endtask

    task automatic test_dmem_yield();
        cyc(0, 0, 0, 5'd0, 0, 5'd0);
        idle(5);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 5'd0, 1, 5'd29);
            checks++;
            if ({seen_maddr, ifid_instr, ifid_valid, pc} !== {5'd29, 20'h0, 1'b0, 5'd5}) begin
                errors++;
                $display("FAIL dmem_yield %0d: maddr=%0d instr=%h v=%b pc=%0d expected 29 0 0 5",
                         i, seen_maddr, ifid_instr, ifid_valid, pc);
            end
        end
        idle(2);
        checks++;
        if ({ifid_pc, ifid_valid, pc} !== {5'd6, 1'b1, 5'd7}) begin
            errors++;
            $display("FAIL dmem_resume: ipc=%0d v=%b pc=%0d expected 6 1 7", ifid_pc, ifid_valid, pc);
        end
    endtask

    task automatic test_stall();
        cyc(0, 0, 0, 5'd0, 0, 5'd0);
        idle(4);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 5'd0, (i == 1), 5'd30);
            checks++;
            if ({ifid_instr, ifid_pc, ifid_valid, pc} !== {mem[3], 5'd3, 1'b1, 5'd4}) begin
                errors++;
                $display("FAIL stall hold %0d: instr=%h ipc=%0d v=%b pc=%0d expected %h 3 1 4",
                         i, ifid_instr, ifid_pc, ifid_valid, pc, mem[3]);
            end
            if (i == 1) begin
                checks++;
                if (seen_maddr !== 5'd30) begin
                    errors++;
                    $display("FAIL stall grant: maddr=%0d expected 30", seen_maddr);
                end
            end
        end
    endtask

    task automatic test_redirect_stall();
        cyc(0, 0, 0, 5'd0, 0, 5'd0);
        idle(7);
        cyc(1, 1, 1, 5'd10, 0, 5'd0);
        checks++;
        if ({pc, ifid_valid} !== {5'd10, 1'b0}) begin
            errors++;
            $display("FAIL redirect_stall: pc=%0d v=%b expected 10 0", pc, ifid_valid);
        end
        idle(1);
        checks++;
        if ({ifid_pc, ifid_valid, ifid_instr} !== {5'd10, 1'b1, mem[10]}) begin
            errors++;
            $display("FAIL redirect_fetch: ipc=%0d v=%b instr=%h expected 10 1 %h",
                     ifid_pc, ifid_valid, ifid_instr, mem[10]);
        end
    endtask

    task automatic test_halt_redirect();
        cyc(0, 0, 0, 5'd0, 0, 5'd0);
        idle(31);
        cyc(1, 0, 1, 5'd2, 0, 5'd0);
        checks++;
        if ({halted, pc} !== {1'b0, 5'd2}) begin
            errors++;
            $display("FAIL halt_exit: h=%b pc=%0d expected 0 2", halted, pc);
        end
        idle(1);
        checks++;
        if ({ifid_pc, ifid_valid} !== {5'd2, 1'b1}) begin
            errors++;
            $display("FAIL halt_resume: ipc=%0d v=%b expected 2 1", ifid_pc, ifid_valid);
        end
        cyc(1, 0, 1, 5'd30, 0, 5'd0);
        idle(1);
        checks++;
        if ({ifid_valid, halted, pc} !== {1'b0, 1'b1, 5'd30}) begin
            errors++;
            $display("FAIL redirect_30: v=%b h=%b pc=%0d expected 0 1 30", ifid_valid, halted, pc);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 5'd0, 0, 5'd0);
        idle(3);
        cyc(1, 0, 0, 5'd0, 1, 5'd31);
        cyc(0, 1, 1, 5'd12, 1, 5'd31);
        checks++;
        if ({pc, ifid_instr, ifid_valid, halted} !== {5'd0, 20'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: pc=%0d instr=%h v=%b h=%b expected zeros",
                     pc, ifid_instr, ifid_valid, halted);
        end
    endtask

    task automatic test_random();
        cyc(0, 0, 0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 600; i++) begin
            logic rn, st, re, dr;
            logic [4:0] rp, da, e_ma;
            rn = ($urandom_range(0, 99) != 0);
            st = ($urandom_range(0, 5) == 0);
            re = ($urandom_range(0, 19) == 0);
            dr = ($urandom_range(0, 4) == 0);
            rp = 5'($urandom);
            da = 5'($urandom);
            e_ma = dr ? da : m_pc;
            if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 31)] = 20'($urandom);
            cyc(rn, st, re, rp, dr, da);
            checks++;
            if ({seen_maddr, pc, ifid_instr, ifid_pc, ifid_valid, halted} !==
                {e_ma, m_pc, m_instr, m_ipc, m_valid, m_halt}) begin
                errors++;
                $display("FAIL random %0d: maddr=%0d pc=%0d instr=%h ipc=%0d v=%b h=%b expected %0d %0d %h %0d %b %b",
                         i, seen_maddr, pc, ifid_instr, ifid_pc, ifid_valid, halted,
                         e_ma, m_pc, m_instr, m_ipc, m_valid, m_halt);
            end
        end
    endtask

    initial begin
        Resetn = 0; stall = 0; redirect_en = 0; redirect_pc = 0; dmem_req = 0; dmem_addr = 0;
        m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halt = 0;
        @(posedge Clock);
        #1;
        test_reset();
        test_free_run();
        test_dmem_yield();
        test_stall();
        test_redirect_stall();
        test_halt_redirect();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 20-bit pipelined processor; sits directly upstream of the unified 32x20 main memory and owns its 5-bit address port.
- Holds the PC, drives the memory address, and registers the returned word into the IF/ID pipeline register.
- Yields the single memory port to the MEM stage on request and inserts bubbles. Honours hazard stalls and branch redirects.
- Stops fetching at the end of the code region; words 29-31 are the data region.

Parameters:
RESET_PC, 5'd0, PC value loaded on reset
LAST_PC, 5'd28, highest instruction address; fetch halts after issuing it
NOP_WORD, 20'h00000, word placed in ifid_instr for every bubble

Ports:
Clock  in  1  system clock, rising-edge registers
Resetn  in  1  synchronous active-low reset
stall  in  1  hazard-unit hold; freeze PC and IF/ID
redirect_en  in  1  branch/jump taken; load redirect_pc and flush
redirect_pc  in  5  redirect target
dmem_req  in  1  MEM stage needs the memory port this cycle
dmem_addr  in  5  MEM-stage address
mem_addr  out  5  to memory addr input
mem_q  in  20  memory read data (combinational read)
ifid_instr  out  20  registered instruction
ifid_pc  out  5  PC of ifid_instr
ifid_valid  out  1  ifid_instr is a real instruction
pc  out  5  current fetch PC
halted  out  1  FSM in HALT

Behaviour:
- Single clock `Clock`. Reset `Resetn` is synchronous, active-low, sampled on the rising edge, and has priority over all other inputs.
- Reset values: pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc=0, ifid_valid=0, halted=0, FSM=RUN.
- mem_addr is combinational: dmem_req ? dmem_addr : pc. Grant depends only on dmem_req, including during stall and HALT.
- FSM states: RUN, YIELD, HALT. YIELD = the previous cycle was given to the MEM stage. It is for observability only; behaviour is the same as RUN.
- Per-edge priority, with Resetn=1: redirect_en > stall > dmem_req > fetch.
- redirect_en=1:
  - pc<=redirect_pc; ifid_instr<=NOP_WORD; ifid_valid<=0.
  - FSM<=RUN from any state; halted<=0.
  - Redirect overrides a simultaneous stall.
  - redirect_pc > LAST_PC is accepted. The next fetch of that address enters HALT per the rule below.
- stall=1: pc, ifid_*, FSM held unchanged. dmem_req is still granted the port.
- dmem_req=1 (no stall): pc held; ifid_instr<=NOP_WORD; ifid_valid<=0; FSM<=YIELD (or stays HALT if in HALT).
- Fetch (RUN/YIELD, no higher-priority input), with pc<=LAST_PC:
  - ifid_instr<=mem_q; ifid_pc<=pc; ifid_valid<=1.
  - If pc==LAST_PC: FSM<=HALT, pc held. Otherwise pc<=pc+1.
- Fetch with pc>LAST_PC: no fetch; bubble; FSM<=HALT.
- HALT:
  - Each unstalled edge writes a bubble (ifid_valid<=0); pc held; halted=1.
  - Exit only by redirect or reset.
- Arithmetic: pc+1 is 5-bit modulo. Wrap 31->0 can only occur with LAST_PC=31, and is then unreachable because HALT is entered at 31.
- Latency: word at address A appears on ifid_instr one edge after mem_addr==A with a fetch granted.
- Timing: memory writes occur on the falling edge. A word written in the same cycle as its fetch is therefore visible to the fetch, because mem_q is sampled at the next rising edge.
- Reset mid-operation: any state returns to the reset values on the next edge, regardless of stall, redirect_en or dmem_req.

Test Plan:
- Reset then free-run, memory preloaded 0..28 with word i = {4'hF, i[3:0], 12'h0}: ifid_pc 0,1,2..., ifid_valid=1 from the second edge; after fetch of 28, halted=1, pc=28, ifid_valid=0 thereafter.
- dmem_req=1 for 2 cycles at pc=5, dmem_addr=29: mem_addr=29 in those cycles; two bubbles (ifid_instr=0, valid=0); pc stays 5, then fetch resumes at 5 with no skipped or duplicated PC.
- stall=1 for 3 cycles with ifid holding pc=3: ifid_instr, ifid_pc, pc unchanged; simultaneous dmem_req=1 still drives mem_addr=dmem_addr.
- redirect_en=1, redirect_pc=10 together with stall=1 at pc=7: next edge pc=10, ifid_valid=0; following edge ifid_pc=10, valid=1.
- In HALT, redirect_pc=2: halted=0, fetch resumes at 2. Separately, redirect_pc=30: one bubble, then HALT.
- Resetn=0 for one edge while in YIELD with stall=1: pc=0, ifid_instr=0, ifid_valid=0, halted=0 on that edge.
